// File: rtl/ramp_adc_sequencer_if.sv
// ----------------------------------------------------------------------------
// ramp_adc_sequencer_if
// Result channel of the ramp ADC sequencer: one conversion result per
// valid/ready handshake.
//   result_data  [7:0]        captured duty value (255 when saturated)
//   result_ch    [CH_W-1:0]   channel the result belongs to
//   result_sat                no comparator falling edge during the sweep
//   result_valid              result is presented and held until accepted
//   result_ready              consumer accepts the result this cycle
// master: the sequencer side; slave: the consumer side.
// ----------------------------------------------------------------------------
interface ramp_adc_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic [7:0]                result_data;
  logic [$clog2(NUM_CH)-1:0] result_ch;
  logic                      result_sat;
  logic                      result_valid;
  logic                      result_ready;

  modport master (
    output result_data,
    output result_ch,
    output result_sat,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result_data,
    input  result_ch,
    input  result_sat,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/ramp_adc_sequencer.sv
// ----------------------------------------------------------------------------
// ramp_adc_sequencer
// Single-slope (ramp) ADC sequencer. For each channel of an analog mux it
// waits for the mux to settle, sweeps a PWM DAC duty from 0 to 255, and
// captures the duty at the first falling edge of the comparator. Results are
// offered on a valid/ready channel; the sequencer stalls until accepted.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   run          level; 1 = convert channels continuously
//   compare      asynchronous comparator output (1 when Vref < Vin)
//   duty_cycle   sawtooth duty to the PWM DAC
//   ch_sel       analog mux select
//   busy         high in every state except IDLE
//   res          result channel (master side of ramp_adc_sequencer_if)
// ----------------------------------------------------------------------------
module ramp_adc_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 64,
  parameter int STEP_CYC   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      compare,
  output logic [7:0]                duty_cycle,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      busy,
  ramp_adc_sequencer_if.master      res
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int SW   = $clog2(SETTLE_CYC) + 1;
  localparam int TW   = $clog2(STEP_CYC) + 1;

  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]   STEP_LAST   = TW'(STEP_CYC - 1);
  localparam logic [CH_W-1:0] CH_LAST     = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RAMP   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [TW-1:0]   step_q, step_d;
  logic [7:0]      duty_q, duty_d;
  logic            cmp_prev_q, cmp_prev_d;
  logic [7:0]      cap_q, cap_d;
  logic            captured_q, captured_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [CH_W-1:0] rch_q, rch_d;
  logic            rsat_q, rsat_d;
  logic            sync1_q, sync2_q;
  logic            cmp_s;
  logic            fall_now;

  // Result of a finished sweep: {sat, data}. A falling edge seen in the very
  // last ramp cycle has not reached cap_q yet, so it is folded in here.
  function automatic logic [8:0] sweep_result(input logic       captured,
                                              input logic [7:0] cap,
                                              input logic       fall,
                                              input logic [7:0] duty);
    if (captured)  return {1'b0, cap};
    else if (fall) return {1'b0, duty};
    else           return {1'b1, 8'hFF};
  endfunction

  assign cmp_s    = sync2_q;
  assign fall_now = !captured_q && cmp_prev_q && !cmp_s;

  // State and datapath registers; synchronizer flops idle at 1 so that a
  // reset never looks like a comparator falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      step_q     <= '0;
      duty_q     <= '0;
      cmp_prev_q <= 1'b1;
      cap_q      <= '0;
      captured_q <= 1'b0;
      ch_q       <= '0;
      rdata_q    <= '0;
      rch_q      <= '0;
      rsat_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      step_q     <= step_d;
      duty_q     <= duty_d;
      cmp_prev_q <= cmp_prev_d;
      cap_q      <= cap_d;
      captured_q <= captured_d;
      ch_q       <= ch_d;
      rdata_q    <= rdata_d;
      rch_q      <= rch_d;
      rsat_q     <= rsat_d;
      sync1_q    <= compare;
      sync2_q    <= sync1_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    step_d     = step_q;
    duty_d     = duty_q;
    cmp_prev_d = cmp_prev_q;
    cap_d      = cap_q;
    captured_d = captured_q;
    ch_d       = ch_q;
    rdata_d    = rdata_q;
    rch_d      = rch_q;
    rsat_d     = rsat_q;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          // cmp_prev starts at 1 so a comparator already low counts as an
          // edge at duty 0.
          state_d    = RAMP;
          cmp_prev_d = 1'b1;
          step_d     = '0;
          duty_d     = '0;
          captured_d = 1'b0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      RAMP: begin
        cmp_prev_d = cmp_s;
        if (fall_now) begin
          cap_d      = duty_q;
          captured_d = 1'b1;
        end
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (duty_q == 8'hFF) begin
            state_d           = HOLD;
            duty_d            = '0;
            {rsat_d, rdata_d} = sweep_result(captured_q, cap_q, fall_now, duty_q);
            rch_d             = ch_q;
          end else begin
            duty_d = duty_q + 8'd1;
          end
        end else begin
          step_d = step_q + TW'(1);
        end
      end
      HOLD: begin
        if (res.result_ready) begin
          ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          state_d  = run ? SETTLE : IDLE;
          settle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    duty_cycle       = duty_q;
    ch_sel           = ch_q;
    busy             = (state_q != IDLE);
    res.result_valid = (state_q == HOLD);
    res.result_data  = rdata_q;
    res.result_ch    = rch_q;
    res.result_sat   = rsat_q;
  end

endmodule

// File: tb/tb_ramp_adc_sequencer.sv
module tb_ramp_adc_sequencer;
  localparam int NUM_CH     = 4;
  localparam int SETTLE_CYC = 4;
  localparam int STEP_CYC   = 4;
  localparam int LAT        = SETTLE_CYC + 256 * STEP_CYC + 1;
  localparam int TMO        = 3000;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       run     = 1'b0;
  logic       compare = 1'b1;
  logic [7:0] duty_cycle;
  logic [1:0] ch_sel;
  logic       busy;

  ramp_adc_sequencer_if #(.NUM_CH(NUM_CH)) res_if ();

  ramp_adc_sequencer #(
    .NUM_CH    (NUM_CH),
    .SETTLE_CYC(SETTLE_CYC),
    .STEP_CYC  (STEP_CYC)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .run       (run),
    .compare   (compare),
    .duty_cycle(duty_cycle),
    .ch_sel    (ch_sel),
    .busy      (busy),
    .res       (res_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sat;
    logic [1:0] ch;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Stimulus steps one clock and acts 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_duty(input logic [7:0] v);
    int k = 0;
    while (duty_cycle !== v && k < TMO) begin
      tick();
      k++;
    end
    if (duty_cycle !== v) check($sformatf("wait_duty_%0d_timeout", v), {24'd0, duty_cycle}, {24'd0, v});
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_if.result_valid !== 1'b1 && n < TMO) begin
      tick();
      n++;
      if (n == 1) run = 1'b0;
    end
    if (res_if.result_valid !== 1'b1) check("wait_valid_timeout", {31'd0, res_if.result_valid}, 1);
  endtask

  task automatic start_run();
    run = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every accepted result.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && res_if.result_valid === 1'b1 && res_if.result_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("result_data", {24'd0, res_if.result_data}, {24'd0, exp_e.data});
          check("result_sat",  {31'd0, res_if.result_sat},  {31'd0, exp_e.sat});
          check("result_ch",   {30'd0, res_if.result_ch},   {30'd0, exp_e.ch});
        end
      end
    end
  end

  initial begin
    int n;
    int bad;
    res_if.result_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_duty",  {24'd0, duty_cycle}, 0);
    check("rst_ch",    {30'd0, ch_sel}, 0);
    check("rst_valid", {31'd0, res_if.result_valid}, 0);
    check("rst_busy",  {31'd0, busy}, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Falling edge at duty 100, channel 0; run dropped after start
    res_if.result_ready = 1'b1;
    exp_q.push_back('{data: 8'd100, sat: 1'b0, ch: 2'd0});
    start_run();
    tick();
    run = 1'b0;
    check("t1_busy", {31'd0, busy}, 1);
    wait_duty(8'd100);
    compare = 1'b0;
    wait_valid(n);
    check("t1_hold_duty", {24'd0, duty_cycle}, 0);
    tick();
    check("t1_valid_drop", {31'd0, res_if.result_valid}, 0);
    check("t1_ch_adv", {30'd0, ch_sel}, 1);
    check("t1_idle", {31'd0, busy}, 0);

    // Comparator never falls: saturated, with latency check
    compare = 1'b1;
    repeat (3) tick();
    exp_q.push_back('{data: 8'd255, sat: 1'b1, ch: 2'd1});
    start_run();
    wait_valid(n);
    check("t2_latency", n, LAT);
    tick();
    check("t2_ch_adv", {30'd0, ch_sel}, 2);

    // Comparator low from SETTLE onward: capture 0
    compare = 1'b0;
    exp_q.push_back('{data: 8'd0, sat: 1'b0, ch: 2'd2});
    start_run();
    wait_valid(n);
    tick();
    check("t3_ch_adv", {30'd0, ch_sel}, 3);

    // Fall at 50, rise at 60, fall at 80: first edge wins; channel wraps
    compare = 1'b1;
    repeat (3) tick();
    exp_q.push_back('{data: 8'd50, sat: 1'b0, ch: 2'd3});
    start_run();
    tick();
    run = 1'b0;
    wait_duty(8'd50);
    compare = 1'b0;
    wait_duty(8'd60);
    compare = 1'b1;
    wait_duty(8'd80);
    compare = 1'b0;
    wait_valid(n);
    tick();
    check("t4_ch_wrap", {30'd0, ch_sel}, 0);

    // Stall in HOLD for 1000 clocks, then one ready pulse
    compare = 1'b1;
    repeat (3) tick();
    res_if.result_ready = 1'b0;
    exp_q.push_back('{data: 8'd200, sat: 1'b0, ch: 2'd0});
    start_run();
    tick();
    run = 1'b0;
    wait_duty(8'd200);
    compare = 1'b0;
    wait_valid(n);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (res_if.result_valid !== 1'b1 || res_if.result_data !== 8'd200 ||
          res_if.result_sat !== 1'b0 || res_if.result_ch !== 2'd0 ||
          duty_cycle !== 8'd0 || ch_sel !== 2'd0 || busy !== 1'b1)
        bad++;
    end
    check("t5_stall_stable_cycles_bad", bad, 0);
    check("t5_not_consumed", exp_q.size(), 1);
    res_if.result_ready = 1'b1;
    tick();
    res_if.result_ready = 1'b0;
    check("t5_valid_drop", {31'd0, res_if.result_valid}, 0);
    check("t5_ch_adv", {30'd0, ch_sel}, 1);
    check("t5_idle", {31'd0, busy}, 0);

    // Reset mid-sweep at duty 128 discards the conversion
    compare = 1'b1;
    res_if.result_ready = 1'b1;
    run = 1'b1;
    wait_duty(8'd128);
    rst_n = 1'b0;
    #1;
    check("t6_rst_duty",  {24'd0, duty_cycle}, 0);
    check("t6_rst_ch",    {30'd0, ch_sel}, 0);
    check("t6_rst_valid", {31'd0, res_if.result_valid}, 0);
    check("t6_rst_busy",  {31'd0, busy}, 0);
    check("t6_rst_data",  {24'd0, res_if.result_data}, 0);
    check("t6_rst_sat",   {31'd0, res_if.result_sat}, 0);
    check("t6_rst_rch",   {30'd0, res_if.result_ch}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back('{data: 8'd255, sat: 1'b1, ch: 2'd0});
    tick();
    check("t6_fresh_busy", {31'd0, busy}, 1);
    check("t6_fresh_ch",   {30'd0, ch_sel}, 0);
    check("t6_fresh_duty", {24'd0, duty_cycle}, 0);
    wait_valid(n);
    check("t6_latency", n + 1, LAT);
    tick();
    check("t6_ch_adv", {30'd0, ch_sel}, 1);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
